// File: rtl/hd44780_pkg.sv
// Shared constants for the HD44780 LCD path: command/character bytes,
// selector codes common with hd44780_control, and the bus FSM encoding.
package hd44780_pkg;

   localparam logic [7:0] CMD_WAKE = 8'h30;
   localparam logic [7:0] CMD_FUNC = 8'h38;
   localparam logic [7:0] CMD_DISP = 8'h0C;
   localparam logic [7:0] CMD_CLR  = 8'h01;
   localparam logic [7:0] CMD_HOME = 8'h80;

   localparam logic [7:0] CH_COLON = 8'h3A;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_A     = 8'h41;
   localparam logic [7:0] CH_P     = 8'h50;
   localparam logic [7:0] CH_M     = 8'h4D;
   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_BAD   = 8'h3F;

   // Command selectors use all three bits.
   localparam logic [2:0] SEL_WAKE = 3'b100;
   localparam logic [2:0] SEL_FUNC = 3'b101;
   localparam logic [2:0] SEL_DISP = 3'b110;
   localparam logic [2:0] SEL_CLR  = 3'b111;
   localparam logic [2:0] SEL_HOME = 3'b000;

   // Character selectors use only the low two bits.
   localparam logic [1:0] SEL_DIGIT = 2'b00;
   localparam logic [1:0] SEL_SEP   = 2'b01;
   localparam logic [1:0] SEL_M     = 2'b10;
   localparam logic [1:0] SEL_AMPM  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_PULSE = 2'd2,
      ST_HOLD  = 2'd3
   } bus_state_e;

endpackage

// File: rtl/hd44780_bus_driver_if.sv
// Symbol stream from hd44780_control plus the LCD pin bundle and status.
interface hd44780_bus_driver_if;

   logic       i_data;
   logic       i_e_trigger;
   logic [2:0] i_sel;
   logic [3:0] i_val;
   logic       o_lcd_rs;
   logic       o_lcd_rw;
   logic       o_lcd_e;
   logic [7:0] o_lcd_db;
   logic       o_busy;
   logic       o_overrun;

   modport master (
      output i_data, i_e_trigger, i_sel, i_val,
      input  o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_db, o_busy, o_overrun
   );

   modport slave (
      input  i_data, i_e_trigger, i_sel, i_val,
      output o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_db, o_busy, o_overrun
   );

endinterface

// File: rtl/hd44780_symbol_decode.sv
// Maps a {data, sel, val} symbol to the HD44780 command or character byte.
module hd44780_symbol_decode
   import hd44780_pkg::*;
(
   input  logic       data,
   input  logic [2:0] sel,
   input  logic [3:0] val,
   output logic [7:0] byte_o
);

   always_comb begin
      byte_o = CMD_HOME;
      if (!data) begin
         unique case (sel)
            SEL_WAKE: byte_o = CMD_WAKE;
            SEL_FUNC: byte_o = CMD_FUNC;
            SEL_DISP: byte_o = CMD_DISP;
            SEL_CLR:  byte_o = CMD_CLR;
            default:  byte_o = CMD_HOME;
         endcase
      end else begin
         unique case (sel[1:0])
            SEL_DIGIT: byte_o = (val <= 4'd9) ? (CH_ZERO + {4'h0, val}) : CH_BAD;
            SEL_SEP:   byte_o = val[0] ? CH_SPACE : CH_COLON;
            SEL_AMPM:  byte_o = val[0] ? CH_P : CH_A;
            SEL_M:     byte_o = CH_M;
            default:   byte_o = CH_BAD;
         endcase
      end
   end

endmodule

// File: rtl/hd44780_bus_driver.sv
// HD44780 8-bit write-only bus driver: edge-detects the slow trigger level and
// emits one E strobe with programmable setup/pulse/hold timing per write.
module hd44780_bus_driver
   import hd44780_pkg::*;
#(
   parameter int unsigned SETUP_CYC = 4,
   parameter int unsigned PULSE_CYC = 50,
   parameter int unsigned HOLD_CYC  = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   hd44780_bus_driver_if.slave  bus
);

   localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
   localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

   bus_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       trig_q, trig_d;
   logic       rs_q, rs_d;
   logic       e_q, e_d;
   logic [7:0] db_q, db_d;
   logic       busy_q, busy_d;
   logic       overrun_q, overrun_d;
   logic       start;
   logic [7:0] dec_byte;

   hd44780_symbol_decode u_decode (
      .data   (bus.i_data),
      .sel    (bus.i_sel),
      .val    (bus.i_val),
      .byte_o (dec_byte)
   );

   assign start = bus.i_e_trigger & ~trig_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      trig_d    = bus.i_e_trigger;
      rs_d      = rs_q;
      e_d       = e_q;
      db_d      = db_q;
      busy_d    = busy_q;
      // An edge in any non-IDLE state, including the final HOLD cycle, is dropped.
      overrun_d = overrun_q | (start & (state_q != ST_IDLE));

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               db_d    = dec_byte;
               rs_d    = bus.i_data;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               e_d     = 1'b1;
               cnt_d   = '0;
               state_d = ST_PULSE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_PULSE: begin
            if (cnt_q == PULSE_LAST) begin
               e_d     = 1'b0;
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         trig_q    <= 1'b0;
         rs_q      <= 1'b0;
         e_q       <= 1'b0;
         db_q      <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         trig_q    <= trig_d;
         rs_q      <= rs_d;
         e_q       <= e_d;
         db_q      <= db_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.o_lcd_rs  = rs_q;
   assign bus.o_lcd_rw  = 1'b0;
   assign bus.o_lcd_e   = e_q;
   assign bus.o_lcd_db  = db_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_hd44780_bus_driver.sv
// Randomized self-checking bench for hd44780_bus_driver against a
// pin-level reference of the LCD write protocol.
module tb_hd44780_bus_driver;

   localparam int S = 4;
   localparam int P = 50;
   localparam int H = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic exp_ovr = 1'b0;

   hd44780_bus_driver_if bus ();

   hd44780_bus_driver #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference byte table written straight from the character/command rules.
   function automatic logic [7:0] ref_byte(input logic d, input logic [2:0] s, input logic [3:0] v);
      int code;
      if (!d) begin
         case (s)
            3'd4:    code = 'h30;
            3'd5:    code = 'h38;
            3'd6:    code = 'h0C;
            3'd7:    code = 'h01;
            default: code = 'h80;
         endcase
      end else begin
         case (s % 4)
            0:       code = (v <= 9) ? ("0" + v) : "?";
            1:       code = (v % 2) ? " " : ":";
            3:       code = (v % 2) ? "P" : "A";
            default: code = "M";
         endcase
      end
      return code[7:0];
   endfunction

   // One write: trigger held for 'hold' cycles, optional re-raise while busy.
   task automatic do_write(input logic d, input logic [2:0] s, input logic [3:0] v,
                           input int hold, input int reraise, input string tag);
      logic [7:0] exp_db;
      int e_first, e_last, b_first, b_last, rises, bcnt, total, bad;
      logic prev_e;
      exp_db  = ref_byte(d, s, v);
      e_first = -1; e_last = -1; b_first = -1; b_last = -1;
      rises = 0; bcnt = 0; bad = 0; prev_e = 1'b0;
      total = S + P + H;
      if (hold > total) total = hold;
      if (reraise + 3 > total) total = reraise + 3;
      total += 3;
      @(negedge clk);
      bus.i_data = d; bus.i_sel = s; bus.i_val = v; bus.i_e_trigger = 1'b1;
      for (int n = 1; n <= total; n++) begin
         @(posedge clk);
         #1;
         if (bus.o_lcd_e && !prev_e) rises++;
         if (bus.o_lcd_e && e_first < 0) e_first = n;
         if (bus.o_lcd_e) e_last = n;
         if (bus.o_busy && b_first < 0) b_first = n;
         if (bus.o_busy) begin
            b_last = n;
            bcnt++;
            if (bus.o_lcd_db !== exp_db || bus.o_lcd_rs !== d) bad++;
         end
         prev_e = bus.o_lcd_e;
         @(negedge clk);
         bus.i_data = 1'($urandom);
         bus.i_sel  = 3'($urandom);
         bus.i_val  = 4'($urandom);
         bus.i_e_trigger = (n < hold) || (reraise > 0 && n >= reraise && n < reraise + 3);
      end
      if (reraise > 0) exp_ovr = 1'b1;
      check_eq({tag, ".rises"}, rises, 1);
      check_eq({tag, ".e_rise"}, e_first, 1 + S);
      check_eq({tag, ".e_width"}, e_last - e_first + 1, P);
      check_eq({tag, ".busy_first"}, b_first, 1);
      check_eq({tag, ".busy_last"}, b_last, S + P + H);
      check_eq({tag, ".busy_cnt"}, bcnt, S + P + H);
      check_eq({tag, ".bus_stable"}, bad, 0);
      check_eq({tag, ".db_kept"}, bus.o_lcd_db, exp_db);
      check_eq({tag, ".rs_kept"}, bus.o_lcd_rs, d);
      check_eq({tag, ".idle"}, {bus.o_lcd_rw, bus.o_lcd_e, bus.o_busy}, 0);
      check_eq({tag, ".overrun"}, bus.o_overrun, exp_ovr);
   endtask

   initial begin
      bus.i_data = 1'b0; bus.i_sel = '0; bus.i_val = '0; bus.i_e_trigger = 1'b0;
      #1;
      check_eq("reset_async", {bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_e, bus.o_lcd_db,
                               bus.o_busy, bus.o_overrun}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         @(posedge clk);
         #1;
         check_eq("idle_zero", {bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_e, bus.o_lcd_db,
                                bus.o_busy, bus.o_overrun}, 0);
      end

      do_write(1'b0, 3'b100, 4'h0, 300, 0, "wake_held");
      check_eq("wake_db", bus.o_lcd_db, 8'h30);
      do_write(1'b1, 3'b000, 4'd7, 3, 0, "digit7");
      check_eq("digit7_db", bus.o_lcd_db, 8'h37);
      do_write(1'b1, 3'b000, 4'd12, 1, 0, "digit12");
      check_eq("digit12_db", bus.o_lcd_db, 8'h3F);
      do_write(1'b1, 3'b011, 4'h1, 2, 0, "char_p");
      check_eq("char_p_db", bus.o_lcd_db, 8'h50);
      do_write(1'b1, 3'b101, 4'h0, 2, 0, "sel2_ignored");
      check_eq("sel2_db", bus.o_lcd_db, 8'h3A);

      for (int k = 0; k < 20; k++) begin
         do_write(1'($urandom), 3'($urandom), 4'($urandom), $urandom_range(1, 120), 0, "rand");
      end

      do_write(1'b0, 3'b110, 4'h0, 5, 20, "overrun");
      do_write(1'b1, 3'b010, 4'h5, 4, 0, "after_ovr");

      // Reset ten cycles into the E pulse.
      @(negedge clk);
      bus.i_data = 1'b1; bus.i_sel = 3'b000; bus.i_val = 4'd3; bus.i_e_trigger = 1'b1;
      for (int n = 1; n <= 1 + S + 10; n++) begin
         @(posedge clk);
         #1;
         if (n == 5) bus.i_e_trigger = 1'b0;
      end
      check_eq("pre_reset_e", bus.o_lcd_e, 1'b1);
      #2;
      rst_n = 1'b0;
      exp_ovr = 1'b0;
      #1;
      check_eq("rst_mid_e", bus.o_lcd_e, 1'b0);
      check_eq("rst_mid_all", {bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_db,
                               bus.o_busy, bus.o_overrun}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      do_write(1'b1, 3'b000, 4'd9, 2, 0, "post_reset");
      check_eq("post_reset_db", bus.o_lcd_db, 8'h39);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
